// File: rtl/math_game_pkg.sv
// Shared types and constants for the mental-arithmetic round sequencer.
// Contents: round FSM state enum, datapath widths, streak ceiling,
// and helpers for tick-counter sizing and the LED thermometer.
package math_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_GAP,
    ST_WAIT_ANS,
    ST_JUDGE,
    ST_RESULT
  } state_t;

  localparam int unsigned OPERAND_W  = 5;
  localparam int unsigned SUM_W      = 8;
  localparam int unsigned STREAK_W   = 3;
  localparam int unsigned STREAK_MAX = 7;
  localparam int unsigned LED_W      = 7;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bit i is lit when the streak exceeds i (streak=3 -> 0000111).
  function automatic logic [LED_W-1:0] thermo(input logic [STREAK_W-1:0] s);
    logic [LED_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      t[i] = (i < {29'b0, s});
    end
    return t;
  endfunction

endpackage

// File: rtl/math_round_ctrl_streak_bar.sv
// streak_bar: saturating win-streak counter and LED thermometer.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   judge_i      - one-cycle pulse when a round is judged
//   correct_i    - verdict accompanying judge_i
//   streak_o     - consecutive correct rounds, saturating at STREAK_MAX
//   led_bar_o    - registered thermometer of streak_o, one cycle behind it
module streak_bar
  import math_game_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                judge_i,
  input  logic                correct_i,
  output logic [STREAK_W-1:0] streak_o,
  output logic [LED_W-1:0]    led_bar_o
);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [LED_W-1:0]    led_q;

  always_comb begin
    streak_d = streak_q;
    if (judge_i) begin
      if (!correct_i) begin
        streak_d = '0;
      end else if (streak_q != STREAK_W'(STREAK_MAX)) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
      led_q    <= '0;
    end else begin
      streak_q <= streak_d;
      led_q    <= thermo(streak_q);
    end
  end

  assign streak_o  = streak_q;
  assign led_bar_o = led_q;

endmodule

// File: rtl/math_round_ctrl.sv
// math_round_ctrl: round sequencer for the mental-arithmetic game.
// Shows NUM_TERMS LFSR operands (each SHOW_TICKS cycles, then GAP_TICKS
// blank), accumulates their sum, waits for the player's answer, judges it
// and holds the correct total for RESULT_TICKS cycles.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - pulse, begins a round (ignored while busy)
//   rnd_in          - current LFSR output, sampled at each operand capture
//   answer, submit  - player answer and commit pulse (WAIT_ANS only)
//   disp_val        - binary value for the BCD converter
//   disp_blank      - display blank request
//   busy            - round in progress
//   result_valid    - one-cycle pulse during judging
//   result_correct  - verdict of last judged round
//   streak, led_bar - win streak and its thermometer
// Build option: define ANSWER_TIMEOUT_EN to time out WAIT_ANS after
// ANS_TICKS cycles with a forced wrong answer.
module math_round_ctrl
  import math_game_pkg::*;
#(
  parameter int unsigned NUM_TERMS    = 5,
  parameter int unsigned SHOW_TICKS   = 10,
  parameter int unsigned GAP_TICKS    = 2,
  parameter int unsigned RESULT_TICKS = 10,
  parameter int unsigned ANS_TICKS    = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPERAND_W-1:0] rnd_in,
  input  logic [SUM_W-1:0]    answer,
  input  logic                submit,
  output logic [SUM_W-1:0]    disp_val,
  output logic                disp_blank,
  output logic                busy,
  output logic                result_valid,
  output logic                result_correct,
  output logic [STREAK_W-1:0] streak,
  output logic [LED_W-1:0]    led_bar
);

  localparam int unsigned TICK_MAX =
    max2(max2(SHOW_TICKS, GAP_TICKS), max2(RESULT_TICKS, ANS_TICKS));
  localparam int unsigned TICK_W = $clog2(TICK_MAX + 1);

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [2:0]           term_q, term_d;
  logic [OPERAND_W-1:0] operand_q, operand_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [SUM_W-1:0]     ans_q, ans_d;
  logic                 correct_q, correct_d;
  logic                 judge_ok;

  assign judge_ok = (ans_q == sum_q);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + 1'b1;
    term_d     = term_q;
    operand_d  = operand_q;
    sum_d      = sum_q;
    ans_d      = ans_q;
    correct_d  = correct_q;
    disp_val   = '0;
    disp_blank = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (start) begin
          state_d   = ST_SHOW;
          operand_d = rnd_in;
          sum_d     = {3'b0, rnd_in};
          term_d    = '0;
        end
      end
      ST_SHOW: begin
        disp_val   = {3'b0, operand_q};
        disp_blank = 1'b0;
        if (tick_q == TICK_W'(SHOW_TICKS - 1)) begin
          state_d = ST_GAP;
          tick_d  = '0;
        end
      end
      ST_GAP: begin
        if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
          tick_d = '0;
          if (term_q == 3'(NUM_TERMS - 1)) begin
            state_d = ST_WAIT_ANS;
          end else begin
            state_d   = ST_SHOW;
            term_d    = term_q + 1'b1;
            operand_d = rnd_in;
            sum_d     = sum_q + {3'b0, rnd_in};
          end
        end
      end
      ST_WAIT_ANS: begin
        disp_val   = answer;
        disp_blank = 1'b0;
`ifdef ANSWER_TIMEOUT_EN
        // A submit on the expiry cycle takes priority over the timeout.
        if (submit) begin
          ans_d   = answer;
          state_d = ST_JUDGE;
          tick_d  = '0;
        end else if (tick_q == TICK_W'(ANS_TICKS - 1)) begin
          ans_d   = 8'hFF;
          state_d = ST_JUDGE;
          tick_d  = '0;
        end
`else
        tick_d = '0;
        if (submit) begin
          ans_d   = answer;
          state_d = ST_JUDGE;
        end
`endif
      end
      ST_JUDGE: begin
        disp_val   = ans_q;
        disp_blank = 1'b0;
        correct_d  = judge_ok;
        state_d    = ST_RESULT;
        tick_d     = '0;
      end
      ST_RESULT: begin
        disp_val   = sum_q;
        disp_blank = 1'b0;
        if (tick_q == TICK_W'(RESULT_TICKS - 1)) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      term_q    <= '0;
      operand_q <= '0;
      sum_q     <= '0;
      ans_q     <= '0;
      correct_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      term_q    <= term_d;
      operand_q <= operand_d;
      sum_q     <= sum_d;
      ans_q     <= ans_d;
      correct_q <= correct_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_JUDGE);
  // Verdict is visible alongside the judge pulse, then held from the register.
  assign result_correct = (state_q == ST_JUDGE) ? judge_ok : correct_q;

  streak_bar u_streak_bar (
    .clk       (clk),
    .rst       (rst),
    .judge_i   (result_valid),
    .correct_i (judge_ok),
    .streak_o  (streak),
    .led_bar_o (led_bar)
  );

endmodule

// File: tb/tb_math_round_ctrl.sv
module tb_math_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] rnd_in;
  logic [7:0] answer;
  logic       submit;
  logic [7:0] disp_val;
  logic       disp_blank;
  logic       busy;
  logic       result_valid;
  logic       result_correct;
  logic [2:0] streak;
  logic [6:0] led_bar;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [4:0]  ops [5];
  int unsigned exp_streak = 0;

  always #5 clk = ~clk;

  math_round_ctrl #(
    .NUM_TERMS(5), .SHOW_TICKS(10), .GAP_TICKS(2), .RESULT_TICKS(10), .ANS_TICKS(200)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rnd_in(rnd_in), .answer(answer),
    .submit(submit), .disp_val(disp_val), .disp_blank(disp_blank), .busy(busy),
    .result_valid(result_valid), .result_correct(result_correct),
    .streak(streak), .led_bar(led_bar)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] therm(input int unsigned s);
    return 7'((1 << s) - 1);
  endfunction

  function automatic logic [7:0] ops_sum();
    int unsigned s = 0;
    for (int i = 0; i < 5; i++) s += ops[i];
    return 8'(s);
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; submit = 1'b0; rnd_in = '0; answer = '0;
    #12;
    n_tests++;
    if (busy !== 1'b0 || disp_blank !== 1'b1 || disp_val !== 8'd0 || result_valid !== 1'b0 ||
        result_correct !== 1'b0 || streak !== 3'd0 || led_bar !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b blank=%0b val=%0d rv=%0b rc=%0b streak=%0d led=%b, expected 0 1 0 0 0 0 0000000",
               busy, disp_blank, disp_val, result_valid, result_correct, streak, led_bar);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
  endtask

  // Starts a round and walks the operand/gap phases; leaves the DUT in WAIT_ANS.
  task automatic play_operands(input bit inject);
    start = 1'b1; rnd_in = ops[0];
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) rnd_in = ops[k+1];
      for (int c = 0; c < 10; c++) begin
        n_tests++;
        if (disp_blank !== 1'b0 || disp_val !== {3'b0, ops[k]} || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL show_op%0d_c%0d: got blank=%0b val=%0d busy=%0b, expected 0 %0d 1",
                   k, c, disp_blank, disp_val, busy, ops[k]);
        end
        if (inject && k == 1 && c == 3) begin
          start = 1'b1; submit = 1'b1; answer = 8'd99;
        end
        tick();
        start = 1'b0; submit = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        n_tests++;
        if (disp_blank !== 1'b1 || disp_val !== 8'd0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_op%0d_c%0d: got blank=%0b val=%0d busy=%0b, expected 1 0 1",
                   k, c, disp_blank, disp_val, busy);
        end
        tick();
      end
    end
  endtask

  // From WAIT_ANS: echo, submit, judge, RESULT hold, back to IDLE.
  task automatic answer_phase(input logic [7:0] ans, input bit exp_ok, input bit do_submit);
    logic [6:0] led_old;
    logic [7:0] s;
    s = ops_sum();
    led_old = therm(exp_streak);
    answer = ans;
    #1;
    n_tests++;
    if (disp_val !== ans || disp_blank !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_echo: got val=%0d blank=%0b busy=%0b rv=%0b, expected %0d 0 1 0",
               disp_val, disp_blank, busy, result_valid, ans);
    end
    if (do_submit) begin
      submit = 1'b1;
      tick();
      submit = 1'b0;
    end
    n_tests++;
    if (result_valid !== 1'b1 || result_correct !== exp_ok) begin
      n_fail++;
      $display("FAIL judge: got rv=%0b rc=%0b, expected 1 %0b", result_valid, result_correct, exp_ok);
    end
    exp_streak = exp_ok ? ((exp_streak < 7) ? exp_streak + 1 : 7) : 0;
    tick();
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (disp_val !== s || disp_blank !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0 ||
          result_correct !== exp_ok) begin
        n_fail++;
        $display("FAIL result_c%0d: got val=%0d blank=%0b busy=%0b rv=%0b rc=%0b, expected %0d 0 1 0 %0b",
                 c, disp_val, disp_blank, busy, result_valid, result_correct, s, exp_ok);
      end
      if (c == 0) begin
        n_tests++;
        if (streak !== 3'(exp_streak) || led_bar !== led_old) begin
          n_fail++;
          $display("FAIL streak_update: got streak=%0d led=%b, expected %0d %b",
                   streak, led_bar, exp_streak, led_old);
        end
      end
      if (c == 1) begin
        n_tests++;
        if (led_bar !== therm(exp_streak)) begin
          n_fail++;
          $display("FAIL led_bar: got %b, expected %b", led_bar, therm(exp_streak));
        end
      end
      tick();
    end
    n_tests++;
    if (busy !== 1'b0 || disp_blank !== 1'b1 || disp_val !== 8'd0 || result_correct !== exp_ok) begin
      n_fail++;
      $display("FAIL back_idle: got busy=%0b blank=%0b val=%0d rc=%0b, expected 0 1 0 %0b",
               busy, disp_blank, disp_val, result_correct, exp_ok);
    end
  endtask

  task automatic set_default_ops();
    ops[0] = 5'd3; ops[1] = 5'd7; ops[2] = 5'd1; ops[3] = 5'd30; ops[4] = 5'd12;
  endtask

  task automatic test_correct();
    set_default_ops();
    play_operands(1'b0);
    answer_phase(8'd53, 1'b1, 1'b1);
  endtask

  task automatic test_wrong();
    set_default_ops();
    play_operands(1'b0);
    answer_phase(8'd52, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    ops[0] = 5'd31; ops[1] = 5'd31; ops[2] = 5'd31; ops[3] = 5'd31; ops[4] = 5'd31;
    for (int r = 0; r < 8; r++) begin
      play_operands(1'b0);
      answer_phase(8'd155, 1'b1, 1'b1);
    end
    n_tests++;
    if (streak !== 3'd7 || led_bar !== 7'b1111111) begin
      n_fail++;
      $display("FAIL saturate: got streak=%0d led=%b, expected 7 1111111", streak, led_bar);
    end
  endtask

  task automatic test_handshake();
    ops[0] = 5'd0; ops[1] = 5'd9; ops[2] = 5'd16; ops[3] = 5'd2; ops[4] = 5'd5;
    play_operands(1'b1);
    answer_phase(8'd32, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_default_ops();
    start = 1'b1; rnd_in = ops[0];
    tick();
    start = 1'b0;
    rnd_in = ops[1];
    repeat (12) tick();
    rnd_in = ops[2];
    repeat (12) tick();
    repeat (4) tick();
    n_tests++;
    if (busy !== 1'b1 || disp_val !== 8'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got busy=%0b val=%0d, expected 1 1", busy, disp_val);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || disp_blank !== 1'b1 || streak !== 3'd0 || led_bar !== 7'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%0b blank=%0b streak=%0d led=%b, expected 0 1 0 0000000",
               busy, disp_blank, streak, led_bar);
    end
    exp_streak = 0;
    tick();
    rst = 1'b0;
    tick();
    ops[0] = 5'd1; ops[1] = 5'd2; ops[2] = 5'd3; ops[3] = 5'd4; ops[4] = 5'd5;
    play_operands(1'b0);
    answer_phase(8'd15, 1'b1, 1'b1);
  endtask

`ifdef ANSWER_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned n;
    set_default_ops();
    play_operands(1'b0);
    answer = 8'd53;
    n = 0;
    while (result_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 200 || result_correct !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got cycles=%0d rc=%0b, expected 200 0", n, result_correct);
    end
    exp_streak = 0;
    repeat (11) tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got busy=%0b, expected 0", busy);
    end
    play_operands(1'b0);
    repeat (199) tick();
    answer_phase(8'd53, 1'b1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_saturate();
    test_handshake();
    test_reset_mid();
`ifdef ANSWER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
